// File: rtl/rate_ctrl_if.sv
// rate_ctrl_if: key inputs and rate/mode outputs of the playback-rate controller.
//   i_up, i_down     speed keys (level, debounced)
//   i_mode           fast/slow toggle key
//   i_interp         interpolation toggle key
//   o_rate           current rate, 1..MAX_RATE
//   o_fast           1 = fast playback, 0 = slow playback
//   o_interp         1 = linear interpolation (slow mode only)
//   o_changed        one-cycle pulse on the cycle after any output changes
// master: key source / output consumer side. slave: the controller.
interface rate_ctrl_if;
  logic       i_up;
  logic       i_down;
  logic       i_mode;
  logic       i_interp;
  logic [3:0] o_rate;
  logic       o_fast;
  logic       o_interp;
  logic       o_changed;

  modport master (
    output i_up, i_down, i_mode, i_interp,
    input  o_rate, o_fast, o_interp, o_changed
  );

  modport slave (
    input  i_up, i_down, i_mode, i_interp,
    output o_rate, o_fast, o_interp, o_changed
  );
endinterface

// File: rtl/rate_ctrl.sv
// rate_ctrl: playback-rate controller. Turns the speed, mode and interpolation
// keys into a saturating 1..MAX_RATE rate, a fast/slow flag and an interpolation
// flag. Holding a speed key auto-repeats the step after REPEAT_DLY cycles, then
// every REPEAT_PER cycles.
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   io_bus    rate_ctrl_if.slave: keys in, rate/fast/interp/changed out
module rate_ctrl #(
  parameter int unsigned MAX_RATE   = 8,
  parameter int unsigned REPEAT_DLY = 12_000_000,
  parameter int unsigned REPEAT_PER = 6_000_000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rate_ctrl_if.slave   io_bus
);

  typedef enum logic [1:0] {StIdle, StWait, StRpt} state_e;

  localparam logic [4:0]  MaxRate5 = 5'(MAX_RATE);
  localparam logic [23:0] DlyLast  = 24'(REPEAT_DLY - 1);
  localparam logic [23:0] PerLast  = 24'(REPEAT_PER - 1);

  logic       w_up, w_down, w_mode, w_interp;
  logic       r_prev_up, r_prev_down, r_prev_mode, r_prev_interp;
  logic       w_up_edge, w_down_edge, w_mode_edge, w_interp_edge;

  state_e     r_state, w_state_d;
  logic [23:0] r_cnt, w_cnt_d;
  logic       r_dir_up, w_dir_up_d;
  logic [3:0] r_rate, w_rate_d;
  logic       r_fast, w_fast_d;
  logic       r_interp, w_interp_d;
  logic       r_changed, w_changed_d;

  logic       w_step, w_step_up;
  logic       w_active, w_other;
  logic [4:0] w_rate_up5, w_rate_dn5;
  logic [3:0] w_rate_up, w_rate_dn;

  assign w_up     = io_bus.i_up;
  assign w_down   = io_bus.i_down;
  assign w_mode   = io_bus.i_mode;
  assign w_interp = io_bus.i_interp;

  assign w_up_edge     = w_up & ~r_prev_up;
  assign w_down_edge   = w_down & ~r_prev_down;
  assign w_mode_edge   = w_mode & ~r_prev_mode;
  assign w_interp_edge = w_interp & ~r_prev_interp;

  // Key selected by the current repeat direction, and the opposing key.
  assign w_active = r_dir_up ? w_up : w_down;
  assign w_other  = r_dir_up ? w_down : w_up;

  // 5-bit arithmetic so a rate of 15 cannot wrap before saturation.
  assign w_rate_up5 = {1'b0, r_rate} + 5'd1;
  assign w_rate_dn5 = {1'b0, r_rate} - 5'd1;
  assign w_rate_up  = (w_rate_up5 > MaxRate5) ? MaxRate5[3:0] : w_rate_up5[3:0];
  assign w_rate_dn  = (r_rate <= 4'd1) ? 4'd1 : w_rate_dn5[3:0];

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_dir_up_d = r_dir_up;
    w_rate_d   = r_rate;
    w_fast_d   = r_fast;
    w_interp_d = r_interp;
    w_step     = 1'b0;
    w_step_up  = r_dir_up;

    if (w_mode_edge) begin
      // Mode change wins: discard any speed edge in the same cycle.
      w_fast_d   = ~r_fast;
      w_rate_d   = 4'd1;
      w_interp_d = 1'b0;
      w_state_d  = StIdle;
      w_cnt_d    = '0;
    end else begin
      if (w_interp_edge && !r_fast) begin
        w_interp_d = ~r_interp;
      end

      case (r_state)
        StIdle: begin
          if (w_up_edge && !w_down) begin
            w_step     = 1'b1;
            w_step_up  = 1'b1;
            w_dir_up_d = 1'b1;
            w_cnt_d    = '0;
            w_state_d  = StWait;
          end else if (w_down_edge && !w_up) begin
            w_step     = 1'b1;
            w_step_up  = 1'b0;
            w_dir_up_d = 1'b0;
            w_cnt_d    = '0;
            w_state_d  = StWait;
          end
        end
        StWait, StRpt: begin
          if (!w_active || w_other) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else if (r_cnt == ((r_state == StWait) ? DlyLast : PerLast)) begin
            w_step    = 1'b1;
            w_cnt_d   = '0;
            w_state_d = StRpt;
          end else begin
            w_cnt_d = r_cnt + 24'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase

      // A saturated step leaves the rate unchanged, so no pulse follows.
      if (w_step) begin
        w_rate_d = w_step_up ? w_rate_up : w_rate_dn;
      end
    end

    w_changed_d = (w_rate_d != r_rate) | (w_fast_d != r_fast) | (w_interp_d != r_interp);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // Previous-key registers reset high: a key held through reset is not a press.
      r_prev_up     <= 1'b1;
      r_prev_down   <= 1'b1;
      r_prev_mode   <= 1'b1;
      r_prev_interp <= 1'b1;
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_dir_up      <= 1'b1;
      r_rate        <= 4'd1;
      r_fast        <= 1'b1;
      r_interp      <= 1'b0;
      r_changed     <= 1'b0;
    end else begin
      r_prev_up     <= w_up;
      r_prev_down   <= w_down;
      r_prev_mode   <= w_mode;
      r_prev_interp <= w_interp;
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_dir_up      <= w_dir_up_d;
      r_rate        <= w_rate_d;
      r_fast        <= w_fast_d;
      r_interp      <= w_interp_d;
      r_changed     <= w_changed_d;
    end
  end

  assign io_bus.o_rate    = r_rate;
  assign io_bus.o_fast    = r_fast;
  assign io_bus.o_interp  = r_interp;
  assign io_bus.o_changed = r_changed;

endmodule

// File: tb/tb_rate_ctrl.sv
// tb_rate_ctrl: directed bench for rate_ctrl with REPEAT_DLY=10, REPEAT_PER=4.
// Each expected o_changed pulse (cycle stamp + output values) is queued by the
// stimulus; a negedge monitor pops and compares whenever o_changed is high.
module tb_rate_ctrl;
  localparam int unsigned MaxRate = 8;
  localparam int unsigned Dly     = 10;
  localparam int unsigned Per     = 4;

  localparam logic [3:0] KNone = 4'b0000;
  localparam logic [3:0] KUp   = 4'b1000;
  localparam logic [3:0] KDn   = 4'b0100;
  localparam logic [3:0] KMode = 4'b0010;
  localparam logic [3:0] KInt  = 4'b0001;

  typedef struct {
    int         cyc;
    logic [3:0] rate;
    logic       fast;
    logic       interp;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t mon_e;

  rate_ctrl_if bus ();

  rate_ctrl #(
    .MAX_RATE  (MaxRate),
    .REPEAT_DLY(Dly),
    .REPEAT_PER(Per)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every o_changed pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && bus.o_changed === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d rate %0d fast %0d interp %0d, required no pulse",
                 cyc, bus.o_rate, bus.o_fast, bus.o_interp);
      end else begin
        mon_e = q.pop_front();
        if (cyc != mon_e.cyc || bus.o_rate !== mon_e.rate || bus.o_fast !== mon_e.fast ||
            bus.o_interp !== mon_e.interp) begin
          n_bad++;
          $display("FAIL pulse: got cycle %0d rate %0d fast %0d interp %0d, required cycle %0d rate %0d fast %0d interp %0d",
                   cyc, bus.o_rate, bus.o_fast, bus.o_interp,
                   mon_e.cyc, mon_e.rate, mon_e.fast, mon_e.interp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int at, input logic [3:0] r, input logic f, input logic i);
    exp_t e;
    e.cyc    = at;
    e.rate   = r;
    e.fast   = f;
    e.interp = i;
    q.push_back(e);
  endtask

  task automatic set_keys(input logic [3:0] k);
    {bus.i_up, bus.i_down, bus.i_mode, bus.i_interp} = k;
  endtask

  // Called at a negedge: keys high for one cycle, then low for one cycle.
  task automatic tap(input logic [3:0] k, input bit pulse, input logic [3:0] r,
                     input logic f, input logic i);
    if (pulse) push(cyc + 1, r, f, i);
    set_keys(k);
    @(negedge clk);
    set_keys(KNone);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_keys(KNone);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int t0;
    set_keys(KNone);

    // Reset values while held in reset.
    @(negedge clk);
    @(negedge clk);
    check("reset_rate", bus.o_rate, 1);
    check("reset_fast", bus.o_fast, 1);
    check("reset_interp", bus.o_interp, 0);
    check("reset_changed", bus.o_changed, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single press.
    tap(KUp, 1'b1, 4'd2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("single_rate", bus.o_rate, 2);
    check("single_fast", bus.o_fast, 1);
    check("single_interp", bus.o_interp, 0);

    // Hold up for 40 cycles from rate 1: 2@t0, 3@t0+10, then every 4 to 8@t0+30.
    do_reset();
    t0 = cyc + 1;
    push(t0, 4'd2, 1'b1, 1'b0);
    push(t0 + 10, 4'd3, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) push(t0 + 14 + 4 * k, 4'(4 + k), 1'b1, 1'b0);
    set_keys(KUp);
    repeat (40) @(negedge clk);
    set_keys(KNone);
    repeat (3) @(negedge clk);
    check("hold_sat_rate", bus.o_rate, 8);

    // Down at rate 1 saturates silently.
    do_reset();
    tap(KDn, 1'b0, 4'd1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("down_sat_rate", bus.o_rate, 1);

    // Chord: up held, down raised at cycle 5 aborts the repeat.
    push(cyc + 1, 4'd2, 1'b1, 1'b0);
    set_keys(KUp);
    repeat (5) @(negedge clk);
    set_keys(KUp | KDn);
    repeat (20) @(negedge clk);
    set_keys(KNone);
    repeat (2) @(negedge clk);
    check("chord_rate", bus.o_rate, 2);

    // Mode and interp.
    do_reset();
    for (int r = 2; r <= 5; r++) tap(KUp, 1'b1, 4'(r), 1'b1, 1'b0);
    check("pre_mode_rate", bus.o_rate, 5);
    tap(KMode, 1'b1, 4'd1, 1'b0, 1'b0);
    check("mode1_fast", bus.o_fast, 0);
    check("mode1_rate", bus.o_rate, 1);
    tap(KInt, 1'b1, 4'd1, 1'b0, 1'b1);
    check("interp_slow", bus.o_interp, 1);
    tap(KMode, 1'b1, 4'd1, 1'b1, 1'b0);
    check("mode2_fast", bus.o_fast, 1);
    check("mode2_interp", bus.o_interp, 0);
    tap(KInt, 1'b0, 4'd1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("interp_fast_ignored", bus.o_interp, 0);

    // Back-to-back pulses: interp edge then mode edge one cycle apart.
    tap(KMode, 1'b1, 4'd1, 1'b0, 1'b0);
    push(cyc + 1, 4'd1, 1'b0, 1'b1);
    push(cyc + 2, 4'd1, 1'b1, 1'b0);
    set_keys(KInt);
    @(negedge clk);
    set_keys(KInt | KMode);
    @(negedge clk);
    set_keys(KNone);
    repeat (2) @(negedge clk);
    check("b2b_fast", bus.o_fast, 1);

    // Simultaneous mode and up edges at rate 3.
    do_reset();
    tap(KUp, 1'b1, 4'd2, 1'b1, 1'b0);
    tap(KUp, 1'b1, 4'd3, 1'b1, 1'b0);
    push(cyc + 1, 4'd1, 1'b0, 1'b0);
    set_keys(KMode | KUp);
    repeat (15) @(negedge clk);
    set_keys(KNone);
    repeat (2) @(negedge clk);
    check("simul_rate", bus.o_rate, 1);
    check("simul_fast", bus.o_fast, 0);

    // Reset mid-repeat at rate 6 with up held.
    do_reset();
    t0 = cyc + 1;
    push(t0, 4'd2, 1'b1, 1'b0);
    push(t0 + 10, 4'd3, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push(t0 + 14 + 4 * k, 4'(4 + k), 1'b1, 1'b0);
    set_keys(KUp);
    repeat (24) @(negedge clk);
    check("pre_rst_rate", bus.o_rate, 6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rate", bus.o_rate, 1);
    check("async_rst_fast", bus.o_fast, 1);
    check("async_rst_interp", bus.o_interp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("held_after_rst_rate", bus.o_rate, 1);
    set_keys(KNone);
    @(negedge clk);
    tap(KUp, 1'b1, 4'd2, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("repress_rate", bus.o_rate, 2);

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rate_ctrl.md
# rate_ctrl

Playback-rate controller for the audio recorder/player. It turns the speed-up, speed-down, mode and interpolation keys into a saturating 1..8 rate, a fast/slow mode flag and an interpolation flag. Holding a speed key auto-repeats the step. Its `o_rate` output drives the rate display decoder directly, and the same outputs feed the playback engine.

## Interface
- `MAX_RATE`, default 8: upper saturation limit of `o_rate` (range 2..15).
- `REPEAT_DLY`, default 12_000_000: cycles from a key-press step to the first auto-repeat step.
- `REPEAT_PER`, default 6_000_000: cycles between subsequent auto-repeat steps.
- `i_clk`  in  1: single clock. All inputs are synchronous to it and already debounced.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_up`  in  1: speed-up key level, active-high.
- `i_down`  in  1: speed-down key level, active-high.
- `i_mode`  in  1: fast/slow toggle key level, active-high.
- `i_interp`  in  1: interpolation toggle key level, active-high.
- `o_rate`  out  4: current rate, always within 1..MAX_RATE.
- `o_fast`  out  1: 1 = fast playback, 0 = slow playback.
- `o_interp`  out  1: 1 = linear interpolation, 0 = zero-order hold. Meaningful only in slow mode.
- `o_changed`  out  1: one-cycle pulse on the cycle after any output value changes.

## Operation
- **Edge detection.** Each key has a previous-value register; a rising edge is `key & ~prev`.
  - The previous-value registers reset to 1, so a key held through reset release does not count as a press.
- **Priority within a cycle:** mode edge > interp edge > speed keys.
- **Mode edge:**
  - Toggles `o_fast`.
  - Forces `o_rate` to 1 and `o_interp` to 0.
  - FSM goes to IDLE and `o_changed` pulses.
  - Any simultaneous up/down edge is discarded.
- **Interp edge:**
  - In slow mode, toggles `o_interp` and pulses `o_changed`.
  - In fast mode, it is ignored and no pulse is produced.
  - Speed-key handling proceeds in the same cycle.
- **FSM states:** IDLE, WAIT, RPT. A 24-bit cycle counter and a direction bit (`dir`) support it.
  - **IDLE:**
    - Up edge with `i_down` low: step up, `dir` = up, counter = 0, go to WAIT.
    - Down edge with `i_up` low: same, with `dir` = down.
    - Both keys high, or an edge while the other key is held: no step, stay in IDLE.
  - **WAIT:**
    - Active key (the one selected by `dir`) released, or the other key goes high: go to IDLE with no step.
    - Otherwise the counter increments. When it reaches `REPEAT_DLY-1`: step, counter = 0, go to RPT.
  - **RPT:**
    - Same abort conditions as WAIT.
    - Otherwise the counter increments. At `REPEAT_PER-1`: step, counter = 0, stay in RPT.
- **Step arithmetic:**
  - Up: `o_rate` = min(`o_rate`+1, `MAX_RATE`).
  - Down: `o_rate` = max(`o_rate`-1, 1).
  - Compute in 5 bits, so there is no wrap at 15.
  - A saturated step changes nothing and produces no `o_changed`. The FSM still advances, so repeat timing continues.
- **Output range:** `o_rate` never leaves 1..`MAX_RATE`, and 0 is never output.

## Timing
- **Reset values:** `o_rate`=1, `o_fast`=1, `o_interp`=0, `o_changed`=0, state IDLE, counter 0, `dir` = up.
- **Reset mid-operation** (any state, key held): all of the above values apply immediately and asynchronously. After release, a held key needs a release and re-press before it steps again.
- **Latency:**
  - The first rising edge of `i_clk` that samples a key high (previously low) updates `o_rate`/`o_fast`/`o_interp` at that same edge.
  - `o_changed` is high for exactly the following cycle.
- **Auto-repeat spacing:**
  - First repeat step: `REPEAT_DLY` cycles after the press step.
  - Later steps: every `REPEAT_PER` cycles while the key stays held.
- **Pulse spacing:** `o_changed` pulses are never merged. The minimum spacing is 1 cycle, for example an interp edge followed by a mode edge.

## Test plan
All scenarios use `REPEAT_DLY`=10 and `REPEAT_PER`=4.
- **Reset and single press:** apply reset, then a 1-cycle `i_up` pulse → `o_rate` goes 1→2 at the sampling edge, `o_changed` is high for one cycle, `o_fast`=1, `o_interp`=0.
- **Hold to saturate:** hold `i_up` for 40 cycles from rate 1 → `o_rate` reaches 2 at t0, 3 at t0+10, then +1 every 4 cycles, and saturates at 8 at t0+30. Exactly 7 `o_changed` pulses occur.
- **Down saturation and chord:** press `i_down` at rate 1 → rate stays 1 with no pulse. Hold `i_up`, then raise `i_down` at cycle 5 → no repeat step occurs; the FSM is in IDLE and a 20-cycle hold yields no further change.
- **Mode and interp:**
  - Rate 5, mode edge → `o_fast`=0, `o_rate`=1, one pulse.
  - `i_interp` edge → `o_interp`=1.
  - Mode edge again → `o_fast`=1, `o_interp`=0.
  - `i_interp` edge in fast mode → no change and no pulse.
- **Simultaneous edges:** `i_mode` and `i_up` rise in the same cycle at rate 3 → `o_rate`=1, `o_fast` toggled, no up-step, one `o_changed` pulse.
- **Reset mid-repeat:** assert `i_rst_n` low while in RPT at rate 6 with `i_up` held → outputs are at reset values immediately. After release with `i_up` still high, there are no steps until `i_up` drops and rises again.
